if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline: owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. It consumes the taken/not-taken result and target resolved in EX, where `branch_out` is gated with the branch opcode. On a taken branch it redirects the PC and squashes the two younger instructions. It also handles load-use stalls from the hazard unit, reports misaligned branch targets, and keeps a redirect counter for performance monitoring.

---
 rtl/if_stage_if.sv | 37 +++
 rtl/if_stage.sv | 109 ++++++++++
 tb/tb_if_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-side bundle of the IF stage: hazard/redirect inputs, instruction
// memory port and the IF/ID pipeline register outputs.
interface if_stage_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        flush_id;

  modport master (
    input  stall,
    input  br_taken,
    input  br_target,
    input  imem_rdata,
    output imem_addr,
    output if_id_pc,
    output if_id_instr,
    output if_id_valid,
    output flush_id
  );

  modport slave (
    output stall,
    output br_taken,
    output br_target,
    output imem_rdata,
    input  imem_addr,
    input  if_id_pc,
    input  if_id_instr,
    input  if_id_valid,
    input  flush_id
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, IF/ID register, EX redirects,
// load-use stalls, misaligned-target halt and a saturating redirect counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus,
  output logic        misalign_err,
  output logic [31:0] err_pc,
  output logic [15:0] redirect_cnt
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic {RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   err_pc_q, err_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush;
  logic              target_misaligned;

  assign target_misaligned = (bus.br_target[1:0] != 2'b00);

  // Next-state and flush: redirect beats stall beats advance; HALT freezes all.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    err_d        = err_q;
    err_pc_d     = err_pc_q;
    cnt_d        = cnt_q;
    flush        = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.br_taken) begin
          flush        = 1'b1;
          ifid_valid_d = 1'b0;
          if (target_misaligned) begin
            state_d  = HALT;
            err_d    = 1'b1;
            err_pc_d = bus.br_target;
          end else begin
            pc_d = bus.br_target;
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end else if (!bus.stall) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = bus.imem_rdata;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + PC_STEP;
        end
      end
      HALT: begin
        ifid_valid_d = 1'b0;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_pc_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      err_q        <= err_d;
      err_pc_q     <= err_pc_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_pc    = ifid_pc_q;
  assign bus.if_id_instr = ifid_instr_q;
  assign bus.if_id_valid = ifid_valid_q;
  assign bus.flush_id    = flush;
  assign misalign_err    = err_q;
  assign err_pc          = err_pc_q;
  assign redirect_cnt    = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed steps from the fetch scenarios plus a random
// phase, all checked against a cycle-level behavioural model.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_stage_if bus ();
  if_stage_if bus2 ();

  logic        misalign_err, misalign_err2;
  logic [31:0] err_pc, err_pc2;
  logic [15:0] redirect_cnt, redirect_cnt2;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  assign bus.imem_rdata  = word_of(bus.imem_addr);
  assign bus2.imem_rdata = word_of(bus2.imem_addr);

  if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .misalign_err(misalign_err), .err_pc(err_pc), .redirect_cnt(redirect_cnt)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .bus(bus2),
    .misalign_err(misalign_err2), .err_pc(err_pc2), .redirect_cnt(redirect_cnt2)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the architectural state
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ifid_pc = 32'h0;
  logic [31:0] m_ifid_instr = 32'h13;
  logic        m_valid = 1'b0;
  logic        m_halt = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_err_pc = 32'h0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic s, input logic bt, input logic [31:0] tgt, input logic r);
    if (r) begin
      m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = 32'h13; m_valid = 1'b0;
      m_halt = 1'b0; m_err = 1'b0; m_err_pc = 32'h0; m_cnt = 0;
    end else if (m_halt) begin
      m_valid = 1'b0;
    end else if (bt) begin
      m_valid = 1'b0;
      if (tgt % 4 != 0) begin
        m_halt = 1'b1; m_err = 1'b1; m_err_pc = tgt;
      end else begin
        m_pc = tgt;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
    end else if (!s) begin
      m_ifid_pc = m_pc; m_ifid_instr = word_of(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  // One clock: drive inputs, check the combinational flush, clock, compare.
  task automatic cycle(input logic s, input logic bt, input logic [31:0] tgt, input logic r);
    rst = r; bus.stall = s; bus.br_taken = bt; bus.br_target = tgt;
    #1;
    chk("flush_id", 32'(bus.flush_id), 32'(!m_halt && bt));
    @(posedge clk); #1;
    model_step(s, bt, tgt, r);
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
    if (m_valid) begin
      chk("if_id_pc", bus.if_id_pc, m_ifid_pc);
      chk("if_id_instr", bus.if_id_instr, m_ifid_instr);
    end
    chk("misalign_err", 32'(misalign_err), 32'(m_err));
    chk("err_pc", err_pc, m_err_pc);
    chk("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
  endtask

  task automatic chk_reset_values();
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
    chk("rst_if_id_pc", bus.if_id_pc, 32'h0);
    chk("rst_if_id_instr", bus.if_id_instr, 32'h13);
    chk("rst_misalign", 32'(misalign_err), 32'h0);
    chk("rst_err_pc", err_pc, 32'h0);
    chk("rst_cnt", 32'(redirect_cnt), 32'h0);
  endtask

  initial begin
    bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = 32'h0;
    bus2.stall = 1'b0; bus2.br_taken = 1'b0; bus2.br_target = 32'h0;

    // Reset, then sequential fetch on both instances
    cycle(0, 0, 32'h0, 1);
    cycle(0, 0, 32'h0, 1);
    chk_reset_values();
    chk("wrap_rst", bus2.imem_addr, 32'hFFFF_FFF8);
    cycle(0, 0, 32'h0, 0);
    chk("seq_addr1", bus.imem_addr, 32'h4);
    chk("seq_ifid0", bus.if_id_pc, 32'h0);
    chk("wrap_1", bus2.imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 32'h0, 0);
    chk("seq_addr2", bus.imem_addr, 32'h8);
    chk("wrap_2", bus2.imem_addr, 32'h0000_0000);
    chk("wrap_ifid", bus2.if_id_pc, 32'hFFFF_FFFC);
    cycle(0, 0, 32'h0, 0);
    chk("seq_addr3", bus.imem_addr, 32'hC);
    chk("wrap_3", bus2.imem_addr, 32'h0000_0004);
    cycle(0, 0, 32'h0, 0);
    chk("at_0x10", bus.imem_addr, 32'h10);

    // Taken branch 0x10 -> 0x40
    cycle(0, 1, 32'h40, 0);
    chk("br_addr", bus.imem_addr, 32'h40);
    chk("br_bubble", 32'(bus.if_id_valid), 32'h0);
    chk("br_cnt", 32'(redirect_cnt), 32'h1);
    cycle(0, 0, 32'h0, 0);
    chk("br_tgt_ifid", bus.if_id_pc, 32'h40);
    chk("br_tgt_valid", 32'(bus.if_id_valid), 32'h1);

    // Stall at pc 0x20, then stall together with a redirect
    cycle(0, 1, 32'h1C, 0);
    cycle(0, 0, 32'h0, 0);
    chk("pre_stall_pc", bus.imem_addr, 32'h20);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 32'h0, 0);
      chk("stall_pc", bus.imem_addr, 32'h20);
      chk("stall_ifid", bus.if_id_pc, 32'h1C);
    end
    cycle(1, 1, 32'h80, 0);
    chk("stall_br_pc", bus.imem_addr, 32'h80);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(99) < 5) t[1:0] = 2'($urandom_range(3, 1));
      cycle(1'($urandom_range(99) < 30), 1'($urandom_range(99) < 15), t,
            1'($urandom_range(99) < 3));
    end

    // Misaligned target halts until reset
    cycle(0, 0, 32'h0, 1);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 1, 32'h42, 0);
    chk("mis_err", 32'(misalign_err), 32'h1);
    chk("mis_err_pc", err_pc, 32'h42);
    chk("mis_pc_frozen", bus.imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cycle(i[0], 1, 32'h100, 0);
      chk("halt_pc", bus.imem_addr, 32'h8);
      chk("halt_valid", 32'(bus.if_id_valid), 32'h0);
    end
    cycle(0, 1, 32'h200, 1);
    chk_reset_values();

    // Saturating redirect counter
    for (int i = 0; i < 65537; i++) begin
      cycle(0, 1, 32'(i) << 2, 0);
    end
    chk("cnt_sat", 32'(redirect_cnt), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
